// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory arbiter
// Holds the access-size encodings, the arbiter FSM state type and the
// master index constants. No ports.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - load lane extraction, extension and alignment check
// Ports: rd_word (memory word), addr_lo (byte offset), size, uns (zero-extend)
// in; ext_data (extended load value, 0 when misaligned) and misaligned out.
// Purely combinational.
module dmem_load_ext
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] ext_data,
  output logic                  misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = rd_word[{addr_lo, 3'b000} +: 8];
    half_lane  = rd_word[{addr_lo[1], 4'b0000} +: 16];
    misaligned = 1'b0;
    ext_data   = '0;
    case (size)
      SZ_BYTE: ext_data = {{(DATA_WIDTH-8){~uns & byte_lane[7]}}, byte_lane};
      SZ_HALF: begin
        if (addr_lo[0]) misaligned = 1'b1;
        else ext_data = {{(DATA_WIDTH-16){~uns & half_lane[15]}}, half_lane};
      end
      SZ_WORD: begin
        if (addr_lo != 2'b00) misaligned = 1'b1;
        else ext_data = rd_word;
      end
      // The reserved size code is rejected like any misaligned access.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter, one access per 3 cycles
// Ports: clk, rst_n (async, active-low); per-master req/we/addr/wdata/size/uns
// (master0 = core in the low slice, master1 = debug loader); gnt completion
// pulse with rdata/err; memory side mem_wr_en/mem_addr/mem_wr_data/
// mem_store_sel out, mem_rd_data (combinational read at mem_addr) in.
// Macro DMEM_ARB_RR_EN: round-robin arbitration; undefined gives fixed
// priority to master0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  input  logic [3:0]              size,
  input  logic [1:0]              uns,
  output logic [1:0]              gnt,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [1:0]              mem_store_sel,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  dmem_state_e            state_q, state_d;
  logic                   winner_q, winner_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
`ifdef DMEM_ARB_RR_EN
  // Master that wins the next simultaneous request.
  logic                   rr_q, rr_d;
`endif

  logic                   pick;
  logic [DATA_WIDTH-1:0]  ext_data;
  logic                   misaligned;

  dmem_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .rd_word   (mem_rd_data),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .ext_data  (ext_data),
    .misaligned(misaligned)
  );

  // Winner among the current requests; only used when some req bit is set.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    pick = (req == 2'b11) ? rr_q : req[1];
`else
    pick = ~req[0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef DMEM_ARB_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          winner_d = pick;
          we_d     = pick ? we[1] : we[0];
          addr_d   = pick ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
          wdata_d  = pick ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
          size_d   = pick ? size[3:2] : size[1:0];
          uns_d    = pick ? uns[1] : uns[0];
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Stores return zero data; misaligned loads already come back as zero.
        rdata_d = we_q ? '0 : ext_data;
        err_d   = misaligned;
        state_d = ST_RESP;
      end
      ST_RESP: begin
`ifdef DMEM_ARB_RR_EN
        rr_d    = ~winner_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= M_CORE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_q     <= M_CORE;
`endif
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef DMEM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Memory side is only driven during ACCESS so reset clears it at once.
  assign mem_wr_en     = (state_q == ST_ACCESS) && we_q && !misaligned;
  assign mem_addr      = (state_q == ST_ACCESS) ? addr_q  : '0;
  assign mem_wr_data   = (state_q == ST_ACCESS) ? wdata_q : '0;
  assign mem_store_sel = (state_q == ST_ACCESS) ? size_q  : 2'b00;

  assign gnt   = (state_q != ST_RESP) ? 2'b00 : (winner_q ? 2'b10 : 2'b01);
  assign err   = (state_q == ST_RESP) && err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  typedef struct {
    int          m;
    bit          is_load;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [3:0]  size_i;
  logic [1:0]  uns_i;
  logic [1:0]  gnt;
  logic [31:0] rdata;
  logic        err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_store_sel;
  logic [31:0] mem_rd_data;

  logic [31:0] ref_mem [0:63];
  logic [31:0] dut_mem [0:63];
  logic        mem_init;

  exp_t sq[$];
  wr_t  wq[$];
  int   ptr;
  int   checks;
  int   errors;
  int   cyc;
  int   wr_cnt;
  int   last_wr_cyc;
  int   last_gnt_cyc;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [1:0]  last_sel;
  exp_t mon_e;
  wr_t  mon_w;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_i),
    .we           (we_i),
    .addr         (addr_i),
    .wdata        (wdata_i),
    .size         (size_i),
    .uns          (uns_i),
    .gnt          (gnt),
    .rdata        (rdata),
    .err          (err),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_store_sel(mem_store_sel),
    .mem_rd_data  (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory placing a store into its byte/half/word lanes.
  function automatic logic [31:0] apply_store(input logic [31:0] w, input logic [1:0] a,
                                              input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return d;
    sh   = (sz == 2'd0) ? 8 * int'(a) : 16 * int'(a[1]);
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  assign mem_rd_data = dut_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) dut_mem <= ref_mem;
    else if (mem_wr_en)
      dut_mem[mem_addr[7:2]] <= apply_store(dut_mem[mem_addr[7:2]], mem_addr[1:0],
                                            mem_wr_data, mem_store_sel);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: one transaction in grant order, pushing its expected outcome.
  function automatic void model_txn(input int m, input bit st, input logic [31:0] a,
                                    input logic [31:0] d, input logic [1:0] sz, input bit u);
    exp_t e;
    wr_t  w;
    logic [31:0] word, v;
    bit mis;
    mis  = (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd1 && a[0]);
    word = ref_mem[a[7:2]];
    e.m = m; e.is_load = !st; e.err = mis; e.rdata = 32'd0;
    if (!mis) begin
      if (st) begin
        ref_mem[a[7:2]] = apply_store(word, a[1:0], d, sz);
        w.addr = a; w.data = d; w.sel = sz;
        wq.push_back(w);
      end else begin
        case (sz)
          2'd0: begin
            v = (word >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!u) v = (v ^ 32'h80) - 32'h80;
          end
          2'd1: begin
            v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!u) v = (v ^ 32'h8000) - 32'h8000;
          end
          default: v = word;
        endcase
        e.rdata = v;
      end
    end
    sq.push_back(e);
    ptr = 1 - m;
  endfunction

  function automatic int both_winner();
`ifdef DMEM_ARB_RR_EN
    return ptr;
`else
    return 0;
`endif
  endfunction

  task automatic set_fields(input int m, input bit st, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz, input bit u);
    we_i[m]            = st;
    addr_i[m*32 +: 32] = a;
    wdata_i[m*32 +: 32] = d;
    size_i[m*2 +: 2]   = sz;
    uns_i[m]           = u;
  endtask

  task automatic wait_gnt(input int m, input bit active);
    bit seen;
    if (!active) return;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (gnt[m]) begin
        seen = 1'b1;
        req_i[m] = 1'b0;
      end
    end
    if (!seen) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      req_i[m] = 1'b0;
    end
  endtask

  int t0;

  task automatic single(input int m, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input bit u);
    @(posedge clk); #1;
    t0 = cyc;
    set_fields(m, st, a, d, sz, u);
    model_txn(m, st, a, d, sz, u);
    req_i[m] = 1'b1;
    wait_gnt(m, 1'b1);
    #1;
  endtask

  task automatic continuous(input int n);
    int cnt, prev, w;
    @(posedge clk); #1;
    set_fields(0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
    set_fields(1, 1'b0, 32'h24, 32'd0, 2'd2, 1'b1);
    w = 0;
    for (int k = 0; k < n; k++) begin
      w = both_winner();
      model_txn(w, 1'b0, (w == 1) ? 32'h24 : 32'h20, 32'd0, 2'd2, w == 1);
    end
    // The last winner withdraws; the other master is then served alone.
    model_txn(1 - w, 1'b0, (w == 0) ? 32'h24 : 32'h20, 32'd0, 2'd2, w == 0);
    req_i = 2'b11;
    cnt = 0;
    prev = -1;
    for (int i = 0; i < 3 * n + 20 && cnt < n + 1; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (prev >= 0) chk("cont_spacing", 32'(cyc - prev), 32'd3);
        prev = cyc;
        cnt++;
        if (cnt == n) req_i[gnt[1]] = 1'b0;
        else if (cnt == n + 1) req_i = 2'b00;
      end
    end
    req_i = 2'b00;
    chk("cont_grants", 32'(cnt), 32'(n + 1));
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes or writes.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        last_sel = mem_store_sel;
        if (wq.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_addr", mem_addr, mon_w.addr);
          chk("wr_data", mem_wr_data, mon_w.data);
          chk("wr_sel", 32'(mem_store_sel), 32'(mon_w.sel));
        end
      end
      if (gnt != 2'b00) begin
        last_gnt_cyc = cyc;
        last_rdata = rdata;
        last_err = err;
        if (sq.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'd0);
        else begin
          mon_e = sq.pop_front();
          chk("gnt_who", 32'(gnt), (mon_e.m == 1) ? 32'd2 : 32'd1);
          chk("gnt_err", 32'(err), 32'(mon_e.err));
          if (mon_e.is_load) chk("gnt_rdata", rdata, mon_e.rdata);
        end
      end else begin
        chk("err_no_gnt", 32'(err), 32'd0);
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdata"}, mem_wr_data, 32'd0);
    chk({tag, "_msel"}, 32'(mem_store_sel), 32'd0);
  endtask

  initial begin
    int w0;
    bit st[2];
    logic [31:0] ra[2], rd[2];
    logic [1:0] rs[2];
    bit ru[2];
    int mask, first;

    checks = 0; errors = 0; wr_cnt = 0; ptr = 0;
    last_wr_cyc = 0; last_gnt_cyc = 0; last_rdata = 0; last_err = 0; last_sel = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0; size_i = '0; uns_i = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[8] = 32'h80FF7F01;

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    mem_init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store from the core.
    single(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    chk("st_wr_cycle", 32'(last_wr_cyc - t0), 32'd1);
    chk("st_gnt_cycle", 32'(last_gnt_cyc - t0), 32'd2);
    chk("st_sel", 32'(last_sel), 32'd2);
    chk("st_err", 32'(last_err), 32'd0);

    // Byte loads from the debug master on 0x80FF7F01.
    single(1, 1'b0, 32'h21, 32'd0, 2'd0, 1'b0);
    chk("ldb_21_s", last_rdata, 32'h0000007F);
    single(1, 1'b0, 32'h22, 32'd0, 2'd0, 1'b0);
    chk("ldb_22_s", last_rdata, 32'hFFFFFFFF);
    single(1, 1'b0, 32'h22, 32'd0, 2'd0, 1'b1);
    chk("ldb_22_u", last_rdata, 32'h000000FF);

    // Misaligned accesses.
    w0 = wr_cnt;
    single(0, 1'b0, 32'h06, 32'd0, 2'd2, 1'b0);
    chk("mis_ldw_err", 32'(last_err), 32'd1);
    chk("mis_ldw_rdata", last_rdata, 32'd0);
    single(0, 1'b1, 32'h03, 32'h5555AAAA, 2'd1, 1'b0);
    chk("mis_sth_err", 32'(last_err), 32'd1);
    single(0, 1'b1, 32'h0C, 32'h5555AAAA, 2'd3, 1'b0);
    chk("mis_sz3_err", 32'(last_err), 32'd1);
    chk("mis_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Both masters requesting back to back.
    continuous(4);

    // Reset pulse during the ACCESS cycle of a store.
    @(posedge clk); #1;
    set_fields(0, 1'b1, 32'h30, 32'h12345678, 2'd2, 1'b0);
    req_i[0] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    req_i = 2'b00;
    ptr = 0;
    set_fields(1, 1'b0, 32'h20, 32'd0, 2'd0, 1'b1);
    model_txn(1, 1'b0, 32'h20, 32'd0, 2'd0, 1'b1);
    req_i[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_gnt(1, 1'b1);
    #1;
    chk("rst_gnt_cycle", 32'(last_gnt_cyc - t0), 32'd2);
    chk("rst_no_write", dut_mem[12], ref_mem[12]);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 40; r++) begin
      @(posedge clk); #1;
      mask = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        st[m] = 1'($urandom_range(0, 1));
        ra[m] = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) ra[m][1:0] = 2'b00;
        rd[m] = $urandom;
        rs[m] = 2'($urandom_range(0, 3));
        ru[m] = 1'($urandom_range(0, 1));
        set_fields(m, st[m], ra[m], rd[m], rs[m], ru[m]);
      end
      first = (mask == 3) ? both_winner() : ((mask == 1) ? 0 : 1);
      model_txn(first, st[first], ra[first], rd[first], rs[first], ru[first]);
      if (mask == 3)
        model_txn(1 - first, st[1-first], ra[1-first], rd[1-first], rs[1-first], ru[1-first]);
      req_i = 2'(mask);
      fork
        wait_gnt(0, mask[0]);
        wait_gnt(1, mask[1]);
      join
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
